// File: rtl/rans_pkg.sv
// Shared FSM encoding and width helpers for the rANS stream encoder.
package rans_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RENORM,
    ST_DIVIDE,
    ST_UPDATE,
    ST_FLUSH
  } rans_state_e;

  // Lower bound L of the normalised state interval.
  function automatic logic [63:0] rans_lower_bound(input int unsigned state_w,
                                                   input int unsigned out_w);
    return 64'd1 << (state_w - out_w);
  endfunction

  function automatic int unsigned rans_chunk_count(input int unsigned state_w,
                                                   input int unsigned out_w);
    return state_w / out_w;
  endfunction

  function automatic int unsigned rans_xmax_width(input int unsigned state_w);
    return state_w + 1;
  endfunction

endpackage

// File: rtl/rans_divider.sv
// Serial restoring divider: one quotient bit per cycle, done on the final iteration.
module rans_divider #(
  parameter int unsigned DIVIDEND_WIDTH = 32,
  parameter int unsigned DIVISOR_WIDTH  = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder
);

  localparam int unsigned CW = $clog2(DIVIDEND_WIDTH);

  logic                     busy;
  logic [CW-1:0]            cnt;
  logic [DIVISOR_WIDTH-1:0] dvs;
  logic [DIVISOR_WIDTH:0]   trial;
  logic                     ge;

  // Dividend bits shift out of the top of quotient as quotient bits shift in.
  always_comb begin
    trial = {remainder, quotient[DIVIDEND_WIDTH-1]};
    ge    = (trial >= {1'b0, dvs});
  end

  // Results are final on the edge that ends the done cycle.
  assign done = busy && (cnt == CW'(DIVIDEND_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      cnt       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start && !busy) begin
      busy      <= 1'b1;
      cnt       <= '0;
      dvs       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (busy) begin
      quotient  <= {quotient[DIVIDEND_WIDTH-2:0], ge};
      remainder <= ge ? DIVISOR_WIDTH'(trial - {1'b0, dvs}) : trial[DIVISOR_WIDTH-1:0];
      cnt       <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rans_stream_encoder.sv
// Streaming rANS encoder: programmable freq/cumul tables, renorm chunk output, flush on last.
module rans_stream_encoder
  import rans_pkg::*;
#(
  parameter int unsigned SYMBOL_WIDTH = 4,
  parameter int unsigned LOG_M        = 10,
  parameter int unsigned STATE_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [SYMBOL_WIDTH-1:0] cfg_sym,
  input  logic [LOG_M:0]          cfg_freq,
  input  logic [LOG_M-1:0]        cfg_cumul,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_last,
  output logic                    err
);

  localparam int unsigned NUM_SYMBOLS = 2 ** SYMBOL_WIDTH;
  localparam int unsigned XW          = rans_xmax_width(STATE_WIDTH);
  localparam int unsigned NCHUNK      = rans_chunk_count(STATE_WIDTH, OUT_WIDTH);
  localparam int unsigned CW          = $clog2(NCHUNK);
  localparam logic [STATE_WIDTH-1:0] L_VAL = STATE_WIDTH'(rans_lower_bound(STATE_WIDTH, OUT_WIDTH));
  localparam logic [XW-1:0]    X_UNIT     = XW'(L_VAL >> LOG_M) << OUT_WIDTH;
  localparam logic [CW-1:0]    LAST_CHUNK = CW'(NCHUNK - 1);

  rans_state_e state, next_state;

  logic [LOG_M:0]           freq_tab  [NUM_SYMBOLS];
  logic [LOG_M-1:0]         cumul_tab [NUM_SYMBOLS];
  logic [LOG_M:0]           lookup_f, sym_f;
  logic [LOG_M-1:0]         lookup_c, sym_c;
  logic                     sym_last;
  logic [STATE_WIDTH-1:0]   x;
  logic [XW-1:0]            x_max;
  logic [CW-1:0]            chunk_idx;
  logic                     div_start, div_done;
  logic [STATE_WIDTH-1:0]   div_q;
  logic [LOG_M:0]           div_r;

  // Combinational table read sees the pre-write entry when cfg_we and a symbol share a cycle.
  assign lookup_f = freq_tab[in_symbol];
  assign lookup_c = cumul_tab[in_symbol];
  assign x_max    = X_UNIT * XW'(sym_f);
  assign out_data = out_valid ? x[OUT_WIDTH-1:0] : '0;

  rans_divider #(
    .DIVIDEND_WIDTH (STATE_WIDTH),
    .DIVISOR_WIDTH  (LOG_M + 1)
  ) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (x),
    .divisor   (sym_f),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    div_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n && (lookup_f != '0)) next_state = ST_RENORM;
      end
      ST_RENORM: begin
        if ({1'b0, x} >= x_max) begin
          out_valid = rst_n;
        end else begin
          div_start  = 1'b1;
          next_state = ST_DIVIDE;
        end
      end
      ST_DIVIDE: if (div_done) next_state = ST_UPDATE;
      ST_UPDATE: next_state = sym_last ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: begin
        out_valid = rst_n;
        out_last  = rst_n && (chunk_idx == LAST_CHUNK);
        if (out_ready && out_last) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      x         <= L_VAL;
      sym_f     <= '0;
      sym_c     <= '0;
      sym_last  <= 1'b0;
      chunk_idx <= '0;
      err       <= 1'b0;
      for (int unsigned i = 0; i < NUM_SYMBOLS; i++) begin
        freq_tab[i]  <= '0;
        cumul_tab[i] <= '0;
      end
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (cfg_we) begin
            freq_tab[cfg_sym]  <= cfg_freq;
            cumul_tab[cfg_sym] <= cfg_cumul;
          end
          if (in_valid) begin
            if (lookup_f == '0) begin
              err <= 1'b1;
            end else begin
              sym_f    <= lookup_f;
              sym_c    <= lookup_c;
              sym_last <= in_last;
            end
          end
        end
        ST_RENORM: if (out_valid && out_ready) x <= x >> OUT_WIDTH;
        ST_UPDATE: begin
          x         <= (div_q << LOG_M) + STATE_WIDTH'(div_r) + STATE_WIDTH'(sym_c);
          chunk_idx <= '0;
        end
        ST_FLUSH: begin
          if (out_ready) begin
            x         <= out_last ? L_VAL : (x >> OUT_WIDTH);
            chunk_idx <= chunk_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
